// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline event inputs and per-stage stall/flush controls.
// Performance counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic        load_use_stall_ai;
  logic        br_redirect_i;
  logic        dmem_req_i;
  logic        dmem_ack_i;
  logic        stall_if_o;
  logic        stall_id_o;
  logic        stall_ex_o;
  logic        stall_mem_o;
  logic        flush_id_o;
  logic        flush_ex_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_o;
  logic [31:0] mem_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    input  lu_cnt_o, mem_cnt_o, flush_cnt_o,
`endif
    output load_use_stall_ai, br_redirect_i, dmem_req_i, dmem_ack_i,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    output lu_cnt_o, mem_cnt_o, flush_cnt_o,
`endif
    input  load_use_stall_ai, br_redirect_i, dmem_req_i, dmem_ack_i,
    output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, branch redirect and memory-wait events into
// per-stage stall/flush enables. Optional perf counters are built when HAZARD_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal flow; new hazards are accepted here
// LU_STALL | extra load-use bubbles pending (lu_ctr counts the remainder)
// FLUSH    | extra front-end flush cycles after a redirect (flush_ctr counts the remainder)
module hazard_ctrl #(
  parameter int LU_BUBBLES     = 1,
  parameter int REDIRECT_FLUSH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [1:0] lu_ctr_q, lu_ctr_d;
  logic [1:0] flush_ctr_q, flush_ctr_d;
  logic       mem_busy;
  logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;

  assign mem_busy = hz.dmem_req_i && !hz.dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      lu_ctr_q    <= '0;
      flush_ctr_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_ctr_q    <= lu_ctr_d;
      flush_ctr_q <= flush_ctr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lu_ctr_d    = lu_ctr_q;
    flush_ctr_d = flush_ctr_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    if (!rst_ni) begin
      state_d = RUN;
    end else if (mem_busy) begin
      // sources of every other event are held, so the FSM simply freezes
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (hz.br_redirect_i) begin
      // a redirect wins in every state: anything stalled is on the wrong path
      flush_id = 1'b1;
      flush_ex = 1'b1;
      if (REDIRECT_FLUSH > 1) begin
        flush_ctr_d = 2'(REDIRECT_FLUSH - 1);
        state_d     = FLUSH;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hz.load_use_stall_ai) begin
            stall_if = 1'b1;
            flush_ex = 1'b1;
            if (LU_BUBBLES > 1) begin
              lu_ctr_d = 2'(LU_BUBBLES - 1);
              state_d  = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          stall_if = 1'b1;
          flush_ex = 1'b1;
          lu_ctr_d = lu_ctr_q - 2'd1;
          if (lu_ctr_q == 2'd1) state_d = RUN;
        end
        FLUSH: begin
          flush_id    = 1'b1;
          flush_ctr_d = flush_ctr_q - 2'd1;
          if (flush_ctr_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.stall_if_o  = stall_if;
  assign hz.stall_id_o  = stall_id;
  assign hz.stall_ex_o  = stall_ex;
  assign hz.stall_mem_o = stall_mem;
  assign hz.flush_id_o  = flush_id;
  assign hz.flush_ex_o  = flush_ex;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;
  logic        lu_evt, redir_evt;

  // a redirect always raises both flushes; a load-use bubble raises flush_ex alone
  assign lu_evt    = flush_ex && !flush_id;
  assign redir_evt = flush_ex && flush_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_evt && (lu_cnt_q != '1))         lu_cnt_q    <= lu_cnt_q + 32'd1;
      if (mem_busy && (mem_cnt_q != '1))      mem_cnt_q   <= mem_cnt_q + 32'd1;
      if (redir_evt && (flush_cnt_q != '1))   flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.lu_cnt_o    = lu_cnt_q;
  assign hz.mem_cnt_o   = mem_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; consumer of the forward unit's load-use stall indication and of the EX-stage branch redirect and data-memory handshake.
- Converts these events into per-stage stall (hold) and flush (bubble) enables for the IF/ID, ID/EX and EX/MEM pipe registers.
- Contains a small FSM and bubble/flush counters so that load latencies and front-end flush depths longer than one cycle are supported.

Parameters:
- LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
- REDIRECT_FLUSH, 1, cycles flush_id_o stays high after a redirect; legal range 1..3.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- load_use_stall_ai  input  1  load-use hazard from the forward unit; combinational, level.
- br_redirect_i  input  1  taken branch/jump resolved in EX; level, one cycle per event.
- dmem_req_i  input  1  MEM stage has an outstanding data-memory request.
- dmem_ack_i  input  1  data memory completes the request this cycle.
- stall_if_o  output  1  hold PC and IF/ID register.
- stall_id_o  output  1  hold ID/EX register.
- stall_ex_o  output  1  hold EX/MEM register.
- stall_mem_o  output  1  hold MEM/WB register.
- flush_id_o  output  1  load NOP into IF/ID.
- flush_ex_o  output  1  load NOP into ID/EX (bubble).
- lu_cnt_o  output  32  load-use bubble count; present only with HAZARD_PERF_EN.
- mem_cnt_o  output  32  memory-wait cycle count; present only with HAZARD_PERF_EN.
- flush_cnt_o  output  32  redirect count; present only with HAZARD_PERF_EN.

Behaviour:
- Reset: asynchronous on rst_ni=0. State goes to RUN, all counters to 0, and every output is 0 while reset is held.
- Reset deasserted mid-stall: the controller resumes from RUN; a pending stall is not remembered.
- mem_busy = dmem_req_i && !dmem_ack_i. This is the highest priority condition.
  - When mem_busy=1, all four stall_*_o are 1 and both flush_*_o are 0.
  - FSM state and all counters are frozen.
  - Other inputs are ignored, because their sources are held.
- Outputs are combinational from state, counters and inputs. There is no added latency.
- FSM states: RUN, LU_STALL, FLUSH.
- RUN, !mem_busy:
  - If br_redirect_i=1: flush_id_o=1, flush_ex_o=1, no stalls. Redirect beats load-use because the stalled instruction is on the wrong path. If REDIRECT_FLUSH>1, load flush_ctr=REDIRECT_FLUSH-1 and go to FLUSH; otherwise stay in RUN.
  - Else if load_use_stall_ai=1: stall_if_o=1, stall_id_o=0, flush_ex_o=1. The ID/EX register receives a bubble and the consuming instruction stays in IF/ID. If LU_BUBBLES>1, load lu_ctr=LU_BUBBLES-1 and go to LU_STALL.
  - Else all outputs are 0.
- LU_STALL, !mem_busy:
  - Outputs: stall_if_o=1, flush_ex_o=1. load_use_stall_ai is ignored.
  - lu_ctr decrements each cycle.
  - When lu_ctr==1 at the clock edge, go to RUN.
  - br_redirect_i=1 here aborts the stall: apply the redirect outputs, then go to FLUSH or RUN exactly as in the RUN state.
- FLUSH, !mem_busy:
  - Outputs: flush_id_o=1, no stalls.
  - flush_ctr decrements each cycle; go to RUN when it reaches 1.
  - A new br_redirect_i reloads flush_ctr=REDIRECT_FLUSH-1 and also asserts flush_ex_o.
  - load_use_stall_ai is ignored in FLUSH.
- Simultaneous dmem_ack_i and another event: the cycle is treated as not busy, and the event is acted on in that same cycle.
- Invariant: stall_id_o=1 always implies stall_if_o=1. A flush and a stall are never asserted on the same register in the same cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Three 32-bit saturating counters (they hold at 0xFFFF_FFFF).
  - lu_cnt_o increments on every cycle with flush_ex_o=1 caused by load-use.
  - mem_cnt_o increments on every mem_busy cycle.
  - flush_cnt_o increments once per accepted br_redirect_i.
  - All three counters reset to 0.
- Undefined: the counters and all three ports are absent, and the behaviour is otherwise identical.

Test Plan:
- Load-use, default parameters: pulse load_use_stall_ai for 1 cycle -> stall_if_o=1 and flush_ex_o=1 for exactly that cycle, stall_id_o=0; the next cycle all outputs are 0.
- Load-use with LU_BUBBLES=3: 1-cycle pulse -> stall_if_o/flush_ex_o high for 3 consecutive cycles; the input held high afterwards causes no extra cycles beyond re-triggering in RUN.
- Redirect with REDIRECT_FLUSH=2, with load_use_stall_ai=1 in the same cycle -> cycle 0: flush_id_o=1, flush_ex_o=1, stall_if_o=0; cycle 1: flush_id_o=1 only; cycle 2: all 0.
- Memory wait: dmem_req_i=1, dmem_ack_i=0 for 4 cycles, then ack; inject load_use_stall_ai during the wait -> all stalls high for 4 cycles, flushes 0; the load-use is serviced on the ack cycle; with HAZARD_PERF_EN, mem_cnt_o=4 and lu_cnt_o=1.
- Reset mid-stall: with LU_BUBBLES=3, drop rst_ni during bubble 2 -> outputs go to 0 immediately (asynchronous); after release, state is RUN and the counters are 0.
- Saturation (HAZARD_PERF_EN): force mem_cnt_o to 0xFFFF_FFFE, hold mem_busy for 3 cycles -> mem_cnt_o stays at 0xFFFF_FFFF.
